// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller.
//   state_e     : controller state encoding (3-bit)
//   DefaultSize : default data/address/burst-length width
package ram_ctrl_pkg;

    localparam int unsigned DefaultSize = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWrite = 3'd2,
        StRead  = 3'd3,
        StResp  = 3'd4
    } state_e;

endpackage

// File: rtl/burst_counter.sv
// Burst address/length tracker for the RAM burst controller.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_addr/load_count as a new burst
//   advance    : step to the next word (address + 1 with wrap, count - 1)
//   load_addr  : burst start address
//   load_count : burst length minus one
//   cur_addr   : address of the current word
//   last       : current word is the final one of the burst
module burst_counter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic [SIZE-1:0] load_addr,
    input  logic [SIZE-1:0] load_count,
    output logic [SIZE-1:0] cur_addr,
    output logic            last
);

    logic [SIZE-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr <= '0;
            count    <= '0;
        end else if (load) begin
            cur_addr <= load_addr;
            count    <= load_count;
        end else if (advance) begin
            // Address wraps modulo 2^SIZE by natural overflow.
            cur_addr <= cur_addr + SIZE'(1);
            count    <= count - SIZE'(1);
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/ram_burst_controller.sv
// Initiator-side controller for a two-phase RAM (load address, then strobe).
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/ready/write/addr/len   : host burst request (len = words - 1)
//   wr_valid/ready/data              : host write word stream
//   rd_valid/ready/data/last         : read word response stream
//   done                             : one-cycle pulse in the first idle cycle after a burst
//   mem_address, mem_set_address     : memory address register load
//   mem_set, mem_data_in             : memory write strobe and data
//   mem_enable, mem_data_out         : memory read enable and data
module ram_burst_controller
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = DefaultSize
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [SIZE-1:0] wr_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [SIZE-1:0] rd_data,
    output logic            rd_last,
    output logic            done,
    output logic [SIZE-1:0] mem_address,
    output logic            mem_set_address,
    output logic            mem_set,
    output logic            mem_enable,
    output logic [SIZE-1:0] mem_data_in,
    input  logic [SIZE-1:0] mem_data_out
);

    state_e          state_q;
    logic            is_write_q;
    logic [SIZE-1:0] cur_addr;
    logic            last;
    logic            cnt_load;
    logic            cnt_advance;

    assign cnt_load    = (state_q == StIdle) && req_valid;
    // Step only when another word follows; the final word leaves the counter untouched.
    assign cnt_advance = !last && (((state_q == StWrite) && wr_valid) ||
                                   ((state_q == StResp) && rd_ready));

    burst_counter #(
        .SIZE(SIZE)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .advance   (cnt_advance),
        .load_addr (req_addr),
        .load_count(req_len),
        .cur_addr  (cur_addr),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        is_write_q <= req_write;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    state_q <= is_write_q ? StWrite : StRead;
                end
                StWrite: begin
                    if (wr_valid) begin
                        if (last) begin
                            state_q <= StIdle;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StAddr;
                        end
                    end
                end
                StRead: begin
                    rd_data <= mem_data_out;
                    state_q <= StResp;
                end
                StResp: begin
                    if (rd_ready) begin
                        if (last) begin
                            state_q <= StIdle;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StAddr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decoded from the registered state; each strobe owns a distinct state,
    // which keeps them mutually exclusive.
    assign req_ready       = (state_q == StIdle);
    assign mem_set_address = (state_q == StAddr);
    assign wr_ready        = (state_q == StWrite);
    assign mem_set         = (state_q == StWrite) && wr_valid;
    assign mem_data_in     = (state_q == StWrite) ? wr_data : '0;
    assign mem_enable      = (state_q == StRead);
    assign rd_valid        = (state_q == StResp);
    assign rd_last         = (state_q == StResp) && last;
    assign mem_address     = cur_addr;

endmodule

// File: tb/tb_ram_burst_controller.sv
// Scoreboard bench for ram_burst_controller with a behavioural RAM and reference memory.
module tb_ram_burst_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready, rd_last, done;
    logic [7:0] rd_data;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
    logic       mem_set_address, mem_set, mem_enable;

    always #5 clk = ~clk;

    ram_burst_controller #(
        .SIZE(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .done           (done),
        .mem_address    (mem_address),
        .mem_set_address(mem_set_address),
        .mem_set        (mem_set),
        .mem_enable     (mem_enable),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out)
    );

    // Behavioural two-phase RAM.
    logic       mem_clear;
    logic [7:0] mem [256];
    logic [7:0] mem_areg;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem_areg <= 8'h00;
        end else begin
            if (mem_set_address) mem_areg <= mem_address;
            if (mem_set) mem[mem_areg] <= mem_data_in;
        end
    end
    assign mem_data_out = mem_enable ? mem[mem_areg] : 8'h00;

    // Reference model and scoreboard queues.
    logic [7:0]  ref_mem [256];
    logic [7:0]  wbuf [256];
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_wr[$];
    logic [8:0]  exp_rd[$];
    int tests = 0, failures = 0, done_seen = 0, done_exp = 0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic bail(string name);
        tests++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    logic [15:0] mon_wr;
    logic [8:0]  mon_rd;
    logic [7:0]  held_data;
    bit          held = 0;
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (mem_set || mem_enable || mem_set_address)
                chk("strobe_onehot", $countones({mem_set, mem_enable, mem_set_address}), 1);
            if (mem_set_address) begin
                if (exp_addr.size() == 0) begin
                    tests++; failures++;
                    $display("FAIL addr_load: got load of 0x%0h, expected none", mem_address);
                end else chk("addr_load", mem_address, exp_addr.pop_front());
            end
            if (mem_set) begin
                chk("mem_set_gated", {wr_valid, wr_ready}, 3);
                if (exp_wr.size() == 0) begin
                    tests++; failures++;
                    $display("FAIL mem_write: got write 0x%0h, expected none", mem_data_in);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    chk("write_addr", mem_areg, mon_wr[15:8]);
                    chk("write_data", mem_data_in, mon_wr[7:0]);
                end
            end
            if (rd_valid) begin
                chk("resp_quiet", {mem_set, mem_enable, mem_set_address}, 0);
                if (held) chk("rd_hold", rd_data, held_data);
                if (rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        tests++; failures++;
                        $display("FAIL rd_beat: got 0x%0h, expected none", rd_data);
                    end else begin
                        mon_rd = exp_rd.pop_front();
                        chk("rd_data", rd_data, mon_rd[8:1]);
                        chk("rd_last", rd_last, mon_rd[0]);
                    end
                end
            end
            held      = rd_valid && !rd_ready;
            held_data = rd_data;
            if (done) done_seen++;
        end
    end

    task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] l);
        int cyc;
        cyc = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        while (!req_ready) begin
            if (cyc >= 50) bail("req_accept");
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom);
        req_addr = 8'($urandom); req_len = 8'($urandom);
        chk("accept_to_addr", mem_set_address, 1);
    endtask

    task automatic push_word(input logic [7:0] d);
        int cyc;
        cyc = 0;
        wr_valid = 1'b1; wr_data = d;
        forever begin
            @(negedge clk);
            if (wr_ready) break;
            cyc++;
            if (cyc > 50) bail("wr_accept");
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] l, input int gmin, input int gmax);
        for (int i = 0; i <= int'(l); i++) begin
            logic [7:0] ad;
            ad = a + 8'(i);
            exp_addr.push_back(ad);
            exp_wr.push_back({ad, wbuf[i]});
            ref_mem[ad] = wbuf[i];
        end
        issue(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (i > 0) chk("wr_addr_phase", mem_set_address, 1);
            repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
            push_word(wbuf[i]);
        end
        chk("done_pulse", done, 1);
        done_exp++;
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("wr_drained", exp_wr.size(), 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] l, input int smin, input int smax,
                           input bit hold, input bit noise);
        for (int i = 0; i <= int'(l); i++) begin
            logic [7:0] ad;
            logic [8:0] e;
            ad = a + 8'(i);
            e  = {ref_mem[ad], (i == int'(l))};
            exp_addr.push_back(ad);
            exp_rd.push_back(e);
        end
        issue(1'b0, a, l);
        if (hold) begin
            req_valid = 1'b1; req_write = 1'($urandom);
            req_addr = 8'($urandom); req_len = 8'($urandom);
        end
        for (int i = 0; i <= int'(l); i++) begin
            int cyc;
            cyc = 0;
            while (!rd_valid) begin
                if (cyc >= 20) bail("rd_valid_wait");
                @(posedge clk); #1; cyc++;
                if (noise) begin wr_valid = 1'($urandom); wr_data = 8'($urandom); end
            end
            chk("rd_latency", cyc, 2);
            repeat ($urandom_range(smax, smin)) begin
                @(posedge clk); #1;
                if (noise) begin wr_valid = 1'($urandom); wr_data = 8'($urandom); end
            end
            rd_ready = 1'b1;
            if (i == int'(l)) begin req_valid = 1'b0; wr_valid = 1'b0; end
            @(posedge clk); #1;
            rd_ready = 1'b0;
        end
        wr_valid = 1'b0;
        chk("done_pulse", done, 1);
        done_exp++;
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("rd_drained", exp_rd.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        mem_clear = 1'b1; rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 8'h00;
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_strobes", {mem_set, mem_enable, mem_set_address}, 0);
        chk("rst_handshakes", {wr_ready, rd_valid, rd_last, done}, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read.
        wbuf[0] = 8'hA5;
        do_write(8'h12, 8'd0, 0, 0);
        do_read(8'h12, 8'd0, 0, 0, 1'b0, 1'b0);

        // Burst with 2-cycle write gaps, read back with wr_valid noise.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        do_write(8'h30, 8'd3, 2, 2);
        do_read(8'h30, 8'd3, 0, 1, 1'b0, 1'b1);

        // Address wrap.
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(8'hFE, 8'd2, 0, 1);
        do_read(8'hFE, 8'd2, 0, 0, 1'b0, 1'b0);

        // Five-cycle read backpressure with req_valid held during the burst.
        do_read(8'h30, 8'd1, 5, 5, 1'b1, 1'b1);

        // Reset during the second word of an eight-word write.
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        exp_addr.push_back(8'h50);
        exp_addr.push_back(8'h51);
        exp_wr.push_back({8'h50, wbuf[0]});
        ref_mem[8'h50] = wbuf[0];
        issue(1'b1, 8'h50, 8'd7);
        push_word(wbuf[0]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_no_done", done, 0);
        chk("abort_strobes", {mem_set, mem_enable, mem_set_address}, 0);
        chk("abort_handshakes", {wr_ready, rd_valid}, 0);
        rst = 1'b0;
        chk("abort_queues", exp_addr.size() + exp_wr.size(), 0);
        do_read(8'h50, 8'd1, 0, 0, 1'b0, 1'b0);

        // Randomised bursts.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a, l;
            a = ($urandom_range(3, 0) == 0) ? 8'(252 + $urandom_range(3, 0)) : 8'($urandom);
            l = 8'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i <= int'(l); i++) wbuf[i] = 8'($urandom);
                do_write(a, l, 0, 3);
            end else begin
                do_read(a, l, 0, 3, 1'($urandom), 1'($urandom));
            end
        end
        do_read(8'hF8, 8'd15, 0, 1, 1'b0, 1'b0);

        chk("done_count", done_seen, done_exp);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ram_burst_controller.md
# ram_burst_controller

Initiator-side controller for the SIZE-bit random access memory. It accepts single or burst read/write requests over a valid/ready host interface. Each request is sequenced into the memory's two-phase protocol: load the memory address register, then strobe the write set or the read enable. Read words are returned on a handshaked response stream. The block sits between the CPU/datapath and the memory unit and is the only agent that drives the memory's control inputs.

## Interface
- SIZE, 8, data width, address width and burst-length width (address space 2^SIZE words)
- clk  in  1  single system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  controller idle and able to accept a request
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  SIZE  start address
- req_len  in  SIZE  burst length minus one (0 = 1 word, 255 = 256 words)
- wr_valid  in  1  write word available
- wr_ready  out  1  controller consuming write word this cycle
- wr_data  in  SIZE  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  host accepts read word
- rd_data  out  SIZE  read word
- rd_last  out  1  rd_data is the final word of the burst
- done  out  1  one-cycle pulse: burst completed
- mem_address  out  SIZE  to memory address input
- mem_set_address  out  1  loads memory address register
- mem_set  out  1  memory write strobe
- mem_enable  out  1  memory read enable
- mem_data_in  out  SIZE  to memory data input
- mem_data_out  in  SIZE  from memory data output

## Operation
- States: IDLE, ADDR, WRITE, READ, RESP. Moore outputs are decoded from the registered state. Internal registers: cur_addr, count, is_write, rd_data, done.
- IDLE: req_ready=1. On req_valid, latch cur_addr=req_addr, count=req_len and is_write=req_write, then go to ADDR. In every other state req_valid is ignored.
- ADDR: mem_address=cur_addr and mem_set_address=1 for exactly one cycle. Next state is WRITE if is_write, else READ.
- WRITE: wr_ready=1, mem_set=wr_valid, mem_data_in=wr_data.
  - If wr_valid=0, stay in WRITE with mem_set=0.
  - If wr_valid=1 and count==0, go to IDLE and set done=1.
  - Otherwise cur_addr+1, count-1, go to ADDR.
- READ: mem_enable=1 for one cycle. rd_data<=mem_data_out at the end of the cycle. Go to RESP.
- RESP: rd_valid=1 and rd_last=(count==0). rd_data is held stable.
  - If rd_ready=1 and count==0, go to IDLE and set done=1.
  - If rd_ready=1 and count!=0, cur_addr+1, count-1, go to ADDR.
  - If rd_ready=0, stay in RESP.
- Address arithmetic is modulo 2^SIZE: 0xFF+1 wraps to 0x00 with no error.
- wr_valid outside WRITE and rd_ready outside RESP have no effect.
- mem_set, mem_enable and mem_set_address are mutually exclusive every cycle.

## Timing
- Reset, sampled at a clk edge with rst=1:
  - State becomes IDLE, so req_ready=1 from the next cycle.
  - cur_addr, count, rd_data, done, mem_address and mem_data_in are 0.
  - All strobes, wr_ready, rd_valid and rd_last are 0.
- Reset mid-burst aborts immediately. The next cycle has no strobes and no done pulse. Words already written stay in memory.
- Write word throughput: 2 cycles minimum (ADDR, WRITE).
- Read word: 3 cycles minimum (ADDR, READ, RESP). rd_valid first rises 2 cycles after leaving IDLE.
- Request accept to first memory strobe: 1 cycle (ADDR follows the accept cycle).
- done is registered. It is high in the first IDLE cycle after the final transfer. A new request may be accepted in that same cycle.
- Back-to-back bursts: minimum 1 IDLE cycle between bursts.

## Structure
- The shared package (ram_ctrl_pkg) holds:
  - state encodings IDLE=0, ADDR=1, WRITE=2, READ=3, RESP=4 (3-bit);
  - default SIZE.
- One sub-module, burst_counter, holds cur_addr/count. It provides load, advance (addr+1 with wrap, count-1) and last = (count==0).
- The FSM, output decode and rd_data capture are in the top module.

## Test plan
- Single write then read: write req_addr=0x12, len=0, wr_data=0xA5.
  - Expect mem_set_address then mem_set with mem_address=0x12 and done one cycle later.
  - Read 0x12: rd_data=0xA5, rd_last=1.
- Burst write 4 words 0x01..0x04 at 0x30 with wr_valid gaps of 2 cycles.
  - mem_set only when wr_valid=1.
  - Read back at 0x30 len=3 returns 0x01..0x04 with rd_last on the 4th only.
- Wrap: write len=2 at 0xFE. Expect addresses 0xFE, 0xFF, 0x00.
- Read backpressure: hold rd_ready=0 for 5 cycles in RESP. rd_data and rd_valid stay stable and no new strobes are issued.
- Reset mid-burst: assert rst during the 2nd word of a len=7 write.
  - Next cycle: req_ready=1, no done, all strobes 0.
  - Word 0 is present in memory.
- Ignored inputs: req_valid held during a burst does not restart it. wr_valid during a read burst causes no mem_set.
